// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S receive channel.
// Optional build macro used by the channel: I2S_RX_SIGN_EXT_EN.
package i2s_pkg;

  localparam int unsigned I2S_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_WS,
    ST_RUNNING
  } i2s_rx_state_e;

`ifdef I2S_RX_SIGN_EXT_EN
  // Replicate bit wlen into every bit above it.
  function automatic logic [I2S_WORD_W-1:0] i2s_rx_sext(input logic [I2S_WORD_W-1:0] w,
                                                        input logic [4:0]            wlen);
    logic [I2S_WORD_W-1:0] r;
    r = w;
    for (int unsigned i = 0; i < I2S_WORD_W; i++) begin
      if (i > 32'(wlen)) r[i] = w[wlen];
    end
    return r;
  endfunction
`endif

endpackage

// File: rtl/i2s_rx_channel_if.sv
// i2s_rx_channel_if: valid/ready word handshake between the I2S RX channel and the RX FIFO.
interface i2s_rx_channel_if;
  import i2s_pkg::*;

  logic [I2S_WORD_W-1:0] fifo_data_o;
  logic                  fifo_data_valid_o;
  logic                  fifo_data_ready_i;
  logic                  fifo_err_o;

  modport master (
    output fifo_data_o,
    output fifo_data_valid_o,
    output fifo_err_o,
    input  fifo_data_ready_i
  );

  modport slave (
    input  fifo_data_o,
    input  fifo_data_valid_o,
    input  fifo_err_o,
    output fifo_data_ready_i
  );
endinterface

// File: rtl/i2s_rx_channel_buf2.sv
// i2s_rx_buf2: 2-entry in-order word buffer, up to two pushes and one pop per cycle.
// A push event is accepted whole or dropped whole so ch0/ch1 pairs never split.
module i2s_rx_buf2
  import i2s_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic [1:0]            push_num_i,
  input  logic [I2S_WORD_W-1:0] push_data0_i,
  input  logic [I2S_WORD_W-1:0] push_data1_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [I2S_WORD_W-1:0] head_o,
  output logic                  drop_o
);

  logic [I2S_WORD_W-1:0] mem_q [2];
  logic                  rd_ptr_q;
  logic [1:0]            cnt_q;
  logic                  pop;
  logic                  accept;
  logic [1:0]            free;
  logic                  wr0;
  logic                  wr1;

  // A pop in the same cycle frees the head slot for this cycle's push.
  always_comb begin
    pop    = (cnt_q != 2'd0) && ready_i;
    free   = 2'd2 - cnt_q + {1'b0, pop};
    accept = (push_num_i != 2'd0) && (push_num_i <= free);
    wr0    = rd_ptr_q ^ cnt_q[0];
    wr1    = ~wr0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      drop_o   <= 1'b0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      drop_o   <= 1'b0;
    end else begin
      drop_o <= (push_num_i != 2'd0) && !accept;
      if (accept) begin
        mem_q[wr0] <= push_data0_i;
        if (push_num_i == 2'd2) mem_q[wr1] <= push_data1_i;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q - {1'b0, pop} + (accept ? push_num_i : 2'd0);
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/i2s_rx_channel.sv
// i2s_rx_channel: slave-mode I2S receiver in the SCK domain feeding the uDMA RX FIFO.
// Build option: define I2S_RX_SIGN_EXT_EN to sign-extend pushed words above bit cfg_wlen_i.
module i2s_rx_channel
  import i2s_pkg::*;
(
  input  logic             sck_i,
  input  logic             rstn_i,
  input  logic             i2s_ch0_i,
  input  logic             i2s_ch1_i,
  input  logic             i2s_ws_i,
  i2s_rx_channel_if.master fifo,
  input  logic             cfg_en_i,
  input  logic             cfg_2ch_i,
  input  logic [4:0]       cfg_wlen_i,
  input  logic [3:0]       cfg_wnum_i,
  input  logic             cfg_lsb_first_i
);

  i2s_rx_state_e         state_q, state_d;
  logic                  r_ws;
  logic                  ws_edge;
  logic [4:0]            bitcnt_q;
  logic [3:0]            wordcnt_q;
  logic                  idle_phase_q;
  logic [I2S_WORD_W-1:0] word0_q, word1_q;
  logic [I2S_WORD_W-1:0] word0_nxt, word1_nxt;
  logic [I2S_WORD_W-1:0] push0, push1;
  logic [4:0]            pos;
  logic                  capture;
  logic                  word_done;
  logic                  restart;
  logic [1:0]            push_num;

  assign ws_edge = i2s_ws_i ^ r_ws;
  assign restart = ws_edge && (state_q != ST_IDLE);
  assign capture = cfg_en_i && (state_q == ST_RUNNING) && !idle_phase_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cfg_en_i) state_d = ST_WAIT_WS;
      ST_WAIT_WS: if (ws_edge) state_d = ST_RUNNING;
      ST_RUNNING: state_d = ST_RUNNING;
      default:    state_d = ST_IDLE;
    endcase
    if (!cfg_en_i) state_d = ST_IDLE;
  end

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      r_ws    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_ws    <= i2s_ws_i;
    end
  end

  // Word register restarts from zero on the first bit, so bits above wlen stay clear.
  always_comb begin
    pos       = cfg_lsb_first_i ? bitcnt_q : (cfg_wlen_i - bitcnt_q);
    word0_nxt = ((bitcnt_q == 5'd0) ? '0 : word0_q) | ({{(I2S_WORD_W-1){1'b0}}, i2s_ch0_i} << pos);
    word1_nxt = ((bitcnt_q == 5'd0) ? '0 : word1_q) | ({{(I2S_WORD_W-1){1'b0}}, i2s_ch1_i} << pos);
    word_done = capture && (bitcnt_q == cfg_wlen_i);
    push_num  = word_done ? (cfg_2ch_i ? 2'd2 : 2'd1) : 2'd0;
  end

`ifdef I2S_RX_SIGN_EXT_EN
  assign push0 = i2s_rx_sext(word0_nxt, cfg_wlen_i);
  assign push1 = i2s_rx_sext(word1_nxt, cfg_wlen_i);
`else
  assign push0 = word0_nxt;
  assign push1 = word1_nxt;
`endif

  // The bit sampled on a WS edge still completes the current word; counters restart after it.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bitcnt_q     <= '0;
      wordcnt_q    <= '0;
      idle_phase_q <= 1'b0;
      word0_q      <= '0;
      word1_q      <= '0;
    end else begin
      if (capture) begin
        word0_q <= word0_nxt;
        word1_q <= word1_nxt;
      end
      if (!cfg_en_i || restart) begin
        bitcnt_q     <= '0;
        wordcnt_q    <= '0;
        idle_phase_q <= 1'b0;
      end else if (capture) begin
        if (word_done) begin
          bitcnt_q  <= '0;
          wordcnt_q <= wordcnt_q + 4'd1;
          if (wordcnt_q == cfg_wnum_i) idle_phase_q <= 1'b1;
        end else begin
          bitcnt_q <= bitcnt_q + 5'd1;
        end
      end
    end
  end

  i2s_rx_buf2 u_buf (
    .clk_i        (sck_i),
    .rstn_i       (rstn_i),
    .flush_i      (!cfg_en_i),
    .push_num_i   (push_num),
    .push_data0_i (push0),
    .push_data1_i (push1),
    .ready_i      (fifo.fifo_data_ready_i),
    .valid_o      (fifo.fifo_data_valid_o),
    .head_o       (fifo.fifo_data_o),
    .drop_o       (fifo.fifo_err_o)
  );

endmodule
